// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - per-channel tone, tap and seed tables for the piano voice bank
// Tables are indexed by channel number; entries 0..7 are the C4..C5 scale at 50 MHz,
// entries 8..15 extend the bank to its 16-channel maximum.
package piano_pkg;

    localparam int MAX_CH     = 16;
    localparam int TBL_DIV_W  = 17;
    localparam int TBL_LFSR_W = 8;

    // Half-period minus one, in clk cycles.
    localparam logic [TBL_DIV_W-1:0] DEFAULT_HALF [MAX_CH] = '{
        17'd95554, 17'd85131, 17'd75841, 17'd71585,
        17'd63774, 17'd56817, 17'd50619, 17'd47777,
        17'd42566, 17'd37921, 17'd35793, 17'd31887,
        17'd28409, 17'd25310, 17'd23889, 17'd21283
    };

    // Galois feedback taps; bit 0 is implied by the feedback wiring.
    localparam logic [TBL_LFSR_W-1:0] TAP [MAX_CH] = '{
        8'h1D, 8'h55, 8'h85, 8'h0B, 8'h15, 8'h45, 8'h1D, 8'h87,
        8'h1D, 8'h2B, 8'h2D, 8'h4D, 8'h5F, 8'h63, 8'h65, 8'h69
    };

    // Non-zero seeds so no channel can start in the lock-up state.
    localparam logic [TBL_LFSR_W-1:0] SEED [MAX_CH] = '{
        8'hFF, 8'hDF, 8'h55, 8'hEF, 8'hF8, 8'h66, 8'hFF, 8'hAA,
        8'h81, 8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h7E, 8'hE7, 8'h99
    };

endpackage

// File: rtl/piano_voice.sv
// rtl/piano_voice.sv - one piano channel: key synchronizer, debounce, tone divider, noise LFSR
// Ports: clk/rst_n (async active-low), key raw level, mode (0 tone / 1 noise), half
// half-period minus one; outputs active debounced level, key_rise/key_fall one-cycle
// pulses, voice audio bit.
module piano_voice #(
    parameter int                LFSR_W  = 8,
    parameter int                DIV_W   = 17,
    parameter int                DB_WAIT = 3,
    parameter int                DB_W    = 3,
    parameter logic [LFSR_W-1:0] TAP     = '0,
    parameter logic [LFSR_W-1:0] SEED    = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key,
    input  logic             mode,
    input  logic [DIV_W-1:0] half,
    output logic             active,
    output logic             key_rise,
    output logic             key_fall,
    output logic             voice
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_WAIT);

    logic              s0_q, s1_q;
    logic              active_q, active_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              phase_q, phase_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step;
    logic              lfsr_fb;
    logic              tick;

    // Debounce: the synchronized level must disagree with active for DB_WAIT+1
    // consecutive edges before active follows it.
    always_comb begin
        active_d = active_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        db_cnt_d = '0;
        if (s1_q != active_q) begin
            if (db_cnt_q == DB_LAST) begin
                active_d = s1_q;
                rise_d   = s1_q;
                fall_d   = !s1_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // >= rather than == so a half shrunk below the running count wraps at once.
    assign tick = active_q && (div_cnt_q >= half);

    // Clearing on active_d drops the divider on the same edge the key releases;
    // counting only starts once active_q is set, giving half+1 cycles to the first toggle.
    always_comb begin
        div_cnt_d = '0;
        phase_d   = 1'b0;
        if (active_d) begin
            div_cnt_d = div_cnt_q;
            phase_d   = phase_q;
            if (tick) begin
                div_cnt_d = '0;
                phase_d   = !phase_q;
            end else if (active_q) begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    assign lfsr_fb   = lfsr_q[LFSR_W-1];
    assign lfsr_step = {lfsr_q[LFSR_W-2:0], lfsr_fb}
                     ^ ({LFSR_W{lfsr_fb}} & {TAP[LFSR_W-1:1], 1'b0});
    assign lfsr_d    = (tick && mode) ? lfsr_step : lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            active_q  <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            db_cnt_q  <= '0;
            div_cnt_q <= '0;
            phase_q   <= 1'b0;
            lfsr_q    <= SEED;
        end else begin
            s0_q      <= key;
            s1_q      <= s0_q;
            active_q  <= active_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            db_cnt_q  <= db_cnt_d;
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
            lfsr_q    <= lfsr_d;
        end
    end

    assign active   = active_q;
    assign key_rise = rise_q;
    assign key_fall = fall_q;
    assign voice    = active_q & (mode ? lfsr_q[LFSR_W-1] : phase_q);

endmodule

// File: rtl/piano_voice_bank.sv
// rtl/piano_voice_bank.sv - NUM_CH-voice piano note generator with run-time half-period config
// Ports: clk/rst_n (async active-low), key[NUM_CH] raw levels, mode (0 tone / 1 noise),
// cfg_we/cfg_ch/cfg_half half-period write; outputs active, key_rise, key_fall, voice
// per channel and mix = registered count of voice bits high.
module piano_voice_bank
    import piano_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int LFSR_W  = 8,
    parameter int DIV_W   = 17,
    parameter int DB_WAIT = 3,
    parameter int DB_W    = 3,
    parameter int MIX_W   = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] key,
    input  logic              mode,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] active,
    output logic [NUM_CH-1:0] key_rise,
    output logic [NUM_CH-1:0] key_fall,
    output logic [NUM_CH-1:0] voice,
    output logic [MIX_W-1:0]  mix
);

    logic [MIX_W-1:0] mix_q, mix_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [DIV_W-1:0] HALF_RST = DIV_W'(DEFAULT_HALF[g]);
        localparam logic [3:0]       CH_ID    = 4'(g);

        logic [DIV_W-1:0] half_q, half_d;

        // Channel numbers past NUM_CH never match, so those writes fall away.
        assign half_d = (cfg_we && cfg_ch == CH_ID) ? cfg_half : half_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) half_q <= HALF_RST;
            else        half_q <= half_d;
        end

        piano_voice #(
            .LFSR_W  (LFSR_W),
            .DIV_W   (DIV_W),
            .DB_WAIT (DB_WAIT),
            .DB_W    (DB_W),
            .TAP     (LFSR_W'(TAP[g])),
            .SEED    (LFSR_W'(SEED[g]))
        ) u_voice (
            .clk      (clk),
            .rst_n    (rst_n),
            .key      (key[g]),
            .mode     (mode),
            .half     (half_q),
            .active   (active[g]),
            .key_rise (key_rise[g]),
            .key_fall (key_fall[g]),
            .voice    (voice[g])
        );
    end

    always_comb begin
        mix_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mix_d = mix_d + MIX_W'(voice[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mix_q <= '0;
        else        mix_q <= mix_d;
    end

    assign mix = mix_q;

endmodule

// File: tb/tb_piano_voice_bank.sv
// tb/tb_piano_voice_bank.sv - self-checking bench for piano_voice_bank against a behavioural model
module tb_piano_voice_bank;

    localparam int NUM_CH  = 8;
    localparam int LFSR_W  = 8;
    localparam int DIV_W   = 17;
    localparam int DB_WAIT = 3;
    localparam int DB_W    = 3;
    localparam int MIX_W   = 4;

    localparam int REF_HALF [NUM_CH] = '{95554, 85131, 75841, 71585, 63774, 56817, 50619, 47777};
    localparam int REF_TAP  [NUM_CH] = '{'h1D, 'h55, 'h85, 'h0B, 'h15, 'h45, 'h1D, 'h87};
    localparam int REF_SEED [NUM_CH] = '{'hFF, 'hDF, 'h55, 'hEF, 'hF8, 'h66, 'hFF, 'hAA};

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] key;
    logic              mode;
    logic              cfg_we;
    logic [3:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_half;
    logic [NUM_CH-1:0] active, key_rise, key_fall, voice;
    logic [MIX_W-1:0]  mix;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: one entry per channel.
    int m_s0 [NUM_CH];
    int m_s1 [NUM_CH];
    int m_act [NUM_CH];
    int m_run [NUM_CH];   // consecutive edges the synchronized key disagreed with active
    int m_rise [NUM_CH];
    int m_fall [NUM_CH];
    int m_cnt [NUM_CH];   // cycles since last wrap
    int m_ph [NUM_CH];
    int m_half [NUM_CH];
    int m_lf [NUM_CH];
    int m_mix;

    always #5 clk = ~clk;

    piano_voice_bank #(
        .NUM_CH  (NUM_CH),
        .LFSR_W  (LFSR_W),
        .DIV_W   (DIV_W),
        .DB_WAIT (DB_WAIT),
        .DB_W    (DB_W),
        .MIX_W   (MIX_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key      (key),
        .mode     (mode),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_half (cfg_half),
        .active   (active),
        .key_rise (key_rise),
        .key_fall (key_fall),
        .voice    (voice),
        .mix      (mix)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_s0[i] = 0; m_s1[i] = 0; m_act[i] = 0; m_run[i] = 0;
            m_rise[i] = 0; m_fall[i] = 0; m_cnt[i] = 0; m_ph[i] = 0;
            m_half[i] = REF_HALF[i];
            m_lf[i] = REF_SEED[i];
        end
        m_mix = 0;
    endtask

    function automatic logic [NUM_CH-1:0] model_voice();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mode) v[i] = (m_act[i] != 0) && (((m_lf[i] >> 7) & 1) != 0);
            else      v[i] = (m_act[i] != 0) && (m_ph[i] != 0);
        end
        return v;
    endfunction

    // Advance the reference by one clock edge using the inputs present before it.
    task automatic model_step();
        logic [NUM_CH-1:0] v;
        int pop;
        int new_act;
        if (!rst_n) begin
            model_reset();
            return;
        end
        v = model_voice();
        pop = 0;
        for (int i = 0; i < NUM_CH; i++) pop += int'(v[i]);
        m_mix = pop;
        for (int i = 0; i < NUM_CH; i++) begin
            // Noise: multiply by x modulo the channel polynomial.
            if (m_act[i] != 0 && m_cnt[i] >= m_half[i] && mode) begin
                if (((m_lf[i] >> 7) & 1) != 0) m_lf[i] = ((m_lf[i] << 1) ^ (REF_TAP[i] | 1)) & 'hFF;
                else                           m_lf[i] = (m_lf[i] << 1) & 'hFF;
            end
            m_rise[i] = 0;
            m_fall[i] = 0;
            new_act = m_act[i];
            if (m_s1[i] == m_act[i]) begin
                m_run[i] = 0;
            end else if (m_run[i] == DB_WAIT) begin
                new_act = m_s1[i];
                m_run[i] = 0;
                if (new_act != 0) m_rise[i] = 1;
                else              m_fall[i] = 1;
            end else begin
                m_run[i]++;
            end
            if (new_act == 0) begin
                m_cnt[i] = 0;
                m_ph[i] = 0;
            end else if (m_act[i] != 0) begin
                if (m_cnt[i] >= m_half[i]) begin
                    m_cnt[i] = 0;
                    m_ph[i] = 1 - m_ph[i];
                end else begin
                    m_cnt[i]++;
                end
            end
            m_act[i] = new_act;
            m_s1[i] = m_s0[i];
            m_s0[i] = int'(key[i]);
        end
        if (cfg_we && int'(cfg_ch) < NUM_CH) m_half[cfg_ch[2:0]] = int'(cfg_half);
    endtask

    task automatic compare_all();
        logic [NUM_CH-1:0] e_act, e_rise, e_fall;
        for (int i = 0; i < NUM_CH; i++) begin
            e_act[i]  = (m_act[i] != 0);
            e_rise[i] = (m_rise[i] != 0);
            e_fall[i] = (m_fall[i] != 0);
        end
        check_eq("active", 32'(active), 32'(e_act));
        check_eq("key_rise", 32'(key_rise), 32'(e_rise));
        check_eq("key_fall", 32'(key_fall), 32'(e_fall));
        check_eq("voice", 32'(voice), 32'(model_voice()));
        check_eq("mix", 32'(mix), 32'(m_mix));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_active(input int ch, input logic lvl, output int n);
        n = 0;
        while (active[ch] !== lvl && n < 200) begin
            cycle();
            n++;
        end
    endtask

    task automatic wait_change(input int ch, output int n);
        logic v0;
        v0 = voice[ch];
        n = 0;
        do begin
            cycle();
            n++;
        end while (voice[ch] === v0 && n < 3000);
    endtask

    task automatic cfg_write(input int ch, input int half);
        cfg_we = 1'b1;
        cfg_ch = 4'(ch);
        cfg_half = DIV_W'(half);
        cycle();
        cfg_we = 1'b0;
    endtask

    initial begin
        int n;
        int acc_r, acc_f, acc_g;
        logic [5:0] pat;

        key = '0; mode = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) cycle();
        check_eq("rst_active", 32'(active), 32'h0);
        check_eq("rst_voice", 32'(voice), 32'h0);
        check_eq("rst_mix", 32'(mix), 32'h0);
        rst_n = 1'b1;
        repeat (2) cycle();

        // Debounced rise and fall on channel 0.
        key[0] = 1'b1;
        wait_active(0, 1'b1, n);
        check_eq("rise_latency", 32'(n), 32'd6);
        acc_r = int'(key_rise[0]);
        acc_f = int'(key_fall[0]);
        repeat (5) begin
            cycle();
            acc_r += int'(key_rise[0]);
            acc_f += int'(key_fall[0]);
        end
        check_eq("rise_pulse_count", 32'(acc_r), 32'd1);
        check_eq("fall_pulse_during_rise", 32'(acc_f), 32'd0);
        key[0] = 1'b0;
        wait_active(0, 1'b0, n);
        check_eq("fall_latency", 32'(n), 32'd6);

        // Three-cycle glitch on channel 3 must be filtered.
        key[3] = 1'b1;
        repeat (3) cycle();
        key[3] = 1'b0;
        acc_g = 0;
        repeat (12) begin
            cycle();
            acc_g += int'(active[3] | key_rise[3] | voice[3]);
        end
        check_eq("glitch_rejected", 32'(acc_g), 32'd0);

        // Tone mode, half = 3: toggle every 4 cycles.
        cfg_write(2, 3);
        key[2] = 1'b1;
        wait_active(2, 1'b1, n);
        wait_change(2, n);
        check_eq("tone_first_toggle", 32'(n), 32'd4);
        wait_change(2, n);
        check_eq("tone_half_period_a", 32'(n), 32'd4);
        wait_change(2, n);
        check_eq("tone_half_period_b", 32'(n), 32'd4);
        key[2] = 1'b0;
        wait_active(2, 1'b0, n);
        check_eq("tone_release_voice", 32'(voice[2]), 32'd0);
        key[2] = 1'b1;
        wait_active(2, 1'b1, n);
        wait_change(2, n);
        check_eq("tone_restart_from_zero", 32'(n), 32'd4);
        key[2] = 1'b0;
        wait_active(2, 1'b0, n);

        // Noise mode, half = 0: LFSR steps every cycle from FF.
        cfg_write(0, 0);
        mode = 1'b1;
        key[0] = 1'b1;
        wait_active(0, 1'b1, n);
        pat = {5'b0, voice[0]};
        repeat (5) begin
            cycle();
            pat = {pat[4:0], voice[0]};
        end
        check_eq("noise_msb_seq", 32'(pat), 32'b111101);
        mode = 1'b0;
        key[0] = 1'b0;
        wait_active(0, 1'b0, n);

        // Shrink half below the running count: wrap on the next edge, then period 22.
        cfg_write(5, 1000);
        key[5] = 1'b1;
        wait_active(5, 1'b1, n);
        repeat (900) cycle();
        cfg_write(5, 10);
        wait_change(5, n);
        check_eq("reconf_wrap_next", 32'(n), 32'd1);
        wait_change(5, n);
        check_eq("reconf_half_a", 32'(n), 32'd11);
        wait_change(5, n);
        check_eq("reconf_half_b", 32'(n), 32'd11);
        key[5] = 1'b0;
        wait_active(5, 1'b0, n);

        // All channels in unison, then reset mid-tone.
        for (int i = 0; i < NUM_CH; i++) cfg_write(i, 9);
        key = '1;
        n = 0;
        while (voice !== '1 && n < 200) begin
            cycle();
            n++;
        end
        check_eq("unison_all_high", 32'(voice), 32'hFF);
        cycle();
        check_eq("mix_eight", 32'(mix), 32'd8);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("async_rst_voice", 32'(voice), 32'h0);
        check_eq("async_rst_mix", 32'(mix), 32'h0);
        check_eq("async_rst_active", 32'(active), 32'h0);
        repeat (2) cycle();
        mode = 1'b1;
        rst_n = 1'b1;
        wait_active(0, 1'b1, n);
        check_eq("post_rst_debounce", 32'(n), 32'd6);
        check_eq("seed_reload_msbs", 32'(voice), 32'hDB);

        // Randomized traffic against the model.
        mode = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 23) == 0) key[i] = ~key[i];
            end
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_ch = 4'($urandom_range(0, 15));
            cfg_half = DIV_W'($urandom_range(0, 30));
            if ($urandom_range(0, 299) == 0) mode = ~mode;
            cycle();
        end
        cfg_we = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piano_voice_bank.md
# piano_voice_bank

Parametrised polyphonic note generator for the FPGA piano. It takes NUM_CH raw key/switch inputs and debounces each one. Each debounced key enables a per-channel tone divider whose half-period can be changed at run time, and a per-channel Galois LFSR provides a noise voice. The block drives per-voice outputs and a registered voice-count mix for the downstream audio/PWM stage.

## Interface
- NUM_CH, 8: number of voice channels (1..16)
- LFSR_W, 8: LFSR width; package tap/seed tables are defined for 8
- DIV_W, 17: tone divider counter width
- DB_WAIT, 3: debounce wait count
- DB_W, 3: debounce counter width; must hold DB_WAIT
- MIX_W, $clog2(NUM_CH+1): mix width

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- key  in  NUM_CH  raw asynchronous key/switch levels
- mode  in  1  0 = square tone, 1 = LFSR noise (global)
- cfg_we  in  1  half-period write strobe
- cfg_ch  in  4  channel written
- cfg_half  in  DIV_W  new half-period minus 1
- active  out  NUM_CH  debounced key levels
- key_rise  out  NUM_CH  1-cycle pulse on debounced rise
- key_fall  out  NUM_CH  1-cycle pulse on debounced fall
- voice  out  NUM_CH  per-channel audio bit
- mix  out  MIX_W  number of voice bits high, registered

## Operation
- **Sync:** two-flop synchronizer per key (s0 then s1).
- **Debounce:** counter db_cnt per channel.
  - s1 == active: db_cnt <= 0.
  - Otherwise, db_cnt == DB_WAIT: active <= s1, db_cnt <= 0, pulse key_rise or key_fall.
  - Otherwise: db_cnt++.
- **Divider:**
  - Active channel: div_cnt counts up. When div_cnt >= half[ch], div_cnt <= 0, phase toggles and tick = 1.
  - Inactive channel: div_cnt = 0, phase = 0, no tick.
- **Tone period:** 2*(half+1) cycles at 50% duty.
- **LFSR:** advances only on tick while mode = 1.
  - fb = lfsr[LFSR_W-1].
  - next[0] = fb.
  - next[i] = lfsr[i-1] ^ (fb & TAP[ch][i]) for i ≥ 1.
  - The LFSR holds state across release and is reloaded only by reset.
- **Voice:** voice[ch] = active[ch] & (mode ? lfsr[LFSR_W-1] : phase).
- **Config:**
  - On cfg_we with cfg_ch < NUM_CH, half[cfg_ch] <= cfg_half in the next cycle.
  - cfg_ch ≥ NUM_CH is ignored.
  - If the running div_cnt ≥ the new half, the counter wraps on the following cycle. The >= compare guarantees there is no 2^DIV_W stall.
- **Mix:** mix <= popcount(voice), 1-cycle latency.
- **Reset values:**
  - active, key_rise, key_fall, voice, mix: 0.
  - db_cnt, div_cnt, phase: 0.
  - half[ch] = DEFAULT_HALF[ch].
  - lfsr[ch] = SEED[ch].

## Timing
- **Key rise:** a key level first sampled at edge k appears on active after edge k+2+DB_WAIT, i.e. 6 edges for DB_WAIT = 3. key_rise is high in the cycle after that edge.
- **Glitch filtering:** pulses shorter than DB_WAIT+1 cycles at s1 are rejected.
- **Edge to voice:** the first phase toggle occurs half+1 cycles after active rises.
- **Simultaneous events:** cfg_we on a channel in the same cycle it wraps; the wrap uses the old half and the new half applies from the next cycle. A key falling mid-period clears the divider immediately on the cycle active falls.
- **Reset mid-operation:** rst_n low clears outputs asynchronously. The first active after release requires a full debounce.

## Structure
- Package piano_pkg holds:
  - DEFAULT_HALF[0..7] = 95554, 85131, 75841, 71585, 63774, 56817, 50619, 47777 (C4..C5 at 50 MHz).
  - TAP[0..7] = 8'h1D, 55, 85, 0B, 15, 45, 1D, 87.
  - SEED[0..7] = 8'hFF, DF, 55, EF, F8, 66, FF, AA.
  - For NUM_CH > 8 the tables are extended in the package.
- Sub-module piano_voice contains one channel (sync, debounce, divider, LFSR) and is generated NUM_CH times.
- The top level contains only the cfg decode, half registers and popcount.

## Test plan
- **Debounced rise:** key[0] 0→1 and held → active[0] rises after 6 edges, key_rise[0] high for exactly 1 cycle, key_fall stays 0.
- **Glitch rejection:** key[3] high for 3 cycles then low → active[3], key_rise[3] and voice[3] remain 0.
- **Tone mode:** cfg ch2 half = 3, mode = 0, key[2] held → voice[2] toggles every 4 cycles (period 8). Release → voice[2] = 0 and div_cnt = 0.
- **Noise mode:** ch0 half = 0, mode = 1, key[0] held → lfsr[0] steps FF, E3, DB one per cycle, and voice[0] follows the MSB.
- **Mid-count reconfig:** ch5 running with half = 1000 and div_cnt = 900, write half = 10 → wrap on the next cycle, then period 22 cycles.
- **Mix and reset:** all 8 keys held, mode = 0, equal halves → mix = 8 while phases are high. Assert rst_n mid-tone → voice = 0 and mix = 0 immediately, and lfsr reloads SEED.
